// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding, size codes and helpers shared by mem_ctrl (IO_GAP only with MEM_CTRL_IO_GAP_EN)
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        LS_RD,
        LS_WR
`ifdef MEM_CTRL_IO_GAP_EN
        , IO_GAP
`endif
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] IO_SEL = 2'b11;

    // Reserved size code 2'b11 behaves as a word access.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: IF/LSU arbiter serialising 1/2/4-byte little-endian accesses onto a byte-wide bus; MEM_CTRL_IO_GAP_EN adds a 2-cycle gap after I/O writes
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          IO_SEL_HI = 17,
    parameter logic [31:0] IDLE_ADDR = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        ls_req_in,
    input  logic        ls_wr_in,
    input  logic [31:0] ls_addr_in,
    input  logic [1:0]  ls_size_in,
    input  logic [31:0] ls_wdata_in,
    output logic        ls_done_out,
    output logic [31:0] ls_rdata_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_t      state, state_nx;
    logic [31:0] addr, wdata, rbuf, cap_word;
    logic [2:0]  nbytes, issue_idx, cap_idx;
    logic        inflight, if_pend, ls_pend;
    logic        is_io, in_rd, accept_ls, accept_if, start;
    logic        issue, capture, last_cap, wr_go, last_wr;
`ifdef MEM_CTRL_IO_GAP_EN
    logic        gap_cnt;
`endif

    assign is_io       = addr[IO_SEL_HI -: 2] == IO_SEL;
    assign if_done_out = if_pend && rdy_in && !clear_in;
    assign ls_done_out = ls_pend && rdy_in;
    assign cap_word    = rbuf | (32'(mem_din) << {cap_idx[1:0], 3'b000});

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    // Arbitration, byte issue/capture decisions, bus outputs and next state.
    always_comb begin
        in_rd     = state == IF_RD || state == LS_RD;
        accept_ls = ls_req_in && !ls_done_out;
        accept_if = if_req_in && !if_done_out && !clear_in;
        start     = state == IDLE && rdy_in && (accept_ls || accept_if);
        issue     = in_rd && rdy_in && issue_idx < nbytes;
        capture   = in_rd && rdy_in && inflight;
        last_cap  = capture && cap_idx == nbytes - 3'd1;
        wr_go     = state == LS_WR && rdy_in && !(is_io && io_buffer_full);
        last_wr   = wr_go && issue_idx == nbytes - 3'd1;
        mem_wr    = wr_go;
        mem_a     = (issue || wr_go) ? addr + 32'(issue_idx) : IDLE_ADDR;
        mem_dout  = wr_go ? 8'(wdata >> {issue_idx[1:0], 3'b000}) : 8'h00;
        state_nx  = state;
        if (state == IF_RD && clear_in) state_nx = IDLE;
        else if (rdy_in) begin
            unique case (state)
                IDLE:         state_nx = !start ? IDLE : accept_ls ? (ls_wr_in ? LS_WR : LS_RD) : IF_RD;
                IF_RD, LS_RD: state_nx = last_cap ? IDLE : state;
`ifdef MEM_CTRL_IO_GAP_EN
                LS_WR:        state_nx = !last_wr ? LS_WR : is_io ? IO_GAP : IDLE;
                IO_GAP:       state_nx = gap_cnt ? IDLE : IO_GAP;
`else
                LS_WR:        state_nx = last_wr ? IDLE : LS_WR;
`endif
                default:      state_nx = IDLE;
            endcase
        end
    end

    // Transaction latch, byte counters, read assembly and done pulses; a low rdy rewinds issue to the first uncaptured byte.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr         <= '0;
            wdata        <= '0;
            rbuf         <= '0;
            nbytes       <= '0;
            issue_idx    <= '0;
            cap_idx      <= '0;
            inflight     <= 1'b0;
            if_pend      <= 1'b0;
            ls_pend      <= 1'b0;
            if_data_out  <= '0;
            ls_rdata_out <= '0;
`ifdef MEM_CTRL_IO_GAP_EN
            gap_cnt      <= 1'b0;
`endif
        end else begin
            if (start) begin
                addr      <= accept_ls ? ls_addr_in : if_addr_in;
                nbytes    <= accept_ls ? size_to_bytes(ls_size_in) : 3'd4;
                wdata     <= ls_wdata_in;
                rbuf      <= '0;
                issue_idx <= '0;
                cap_idx   <= '0;
                inflight  <= 1'b0;
            end
            if (in_rd && !rdy_in) begin
                issue_idx <= cap_idx;
                inflight  <= 1'b0;
            end else if (in_rd) begin
                issue_idx <= issue_idx + 3'(issue);
                inflight  <= issue;
                if (capture) begin
                    rbuf    <= cap_word;
                    cap_idx <= cap_idx + 3'd1;
                end
            end
            if (wr_go) issue_idx <= issue_idx + 3'd1;
            if (ls_done_out) ls_pend <= 1'b0;
            if (if_done_out || clear_in) if_pend <= 1'b0;
            if (last_cap && state == IF_RD && !clear_in) begin
                if_data_out <= cap_word;
                if_pend     <= 1'b1;
            end
            if (last_cap && state == LS_RD) begin
                ls_rdata_out <= cap_word;
                ls_pend      <= 1'b1;
            end
            if (last_wr) ls_pend <= 1'b1;
`ifdef MEM_CTRL_IO_GAP_EN
            if (state == IO_GAP && rdy_in) gap_cnt <= ~gap_cnt;
`endif
        end
    end

endmodule
